dp_sequencer: RTL and testbench
===============================

# dp_sequencer

Instruction sequencer that drives the register-file/ALU datapath's control inputs (read/write addresses, write enable, writeback select, ALU op, immediate data). It accepts 32-bit instruction words on a valid/ready handshake, issues one datapath operation per instruction, and captures the datapath's zero and overflow flags into status registers. It supports conditional skip on the zero flag. It sits between an instruction source (test host or fetch unit) and the datapath top.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction word present
- in_ready  out  1  sequencer can accept; transfer on in_valid & in_ready at a rising edge
- in_instr  in  32  instruction word
- in_imm  in  32  immediate for LDI, sampled with in_instr
- dp_ra, dp_rb, dp_rw  out  5 each  datapath read A / read B / write register addresses
- dp_we  out  1  register-file write enable
- dp_s  out  1  writeback select: 0 = ALU result, 1 = dp_rd
- dp_aluc  out  2  ALU op: 00 add, 01 sub, 10 and, 11 or
- dp_rd  out  32  immediate write data
- dp_z, dp_v  in  1 each  datapath zero / signed-overflow flags (combinational from current dp_* drive)
- z_flag, v_flag  out  1 each  flags from the last ALU/CMP
- ovf_sticky  out  1  set by any ALU/CMP overflow
- err  out  1  sticky illegal-opcode flag
- clr_sticky  in  1  clears ovf_sticky and err
- retire  out  1  high for exactly the ISSUE cycle of each executed instruction
- retire_cnt  out  CNT_W  executed-instruction count, wraps modulo 2^CNT_W

## Operation
- Opcode in_instr[31:29]: 000 NOP, 001 ALU, 010 LDI, 011 CMP, 100 SKZ, 101–111 illegal.
- Fields: aluc=[28:27], rw=[26:22], ra=[21:17], rb=[16:12]; other bits ignored.
- FSM states IDLE, ISSUE. in_ready = (state==IDLE).
- On accept in IDLE:
  - If skip_pending: discard the word, clear skip_pending, stay IDLE, no retire, no count.
  - Else if illegal: set err, stay IDLE, no retire.
  - Else: register dp_* from decode, go to ISSUE.
- Drive in ISSUE:
  - ALU: dp_we=1, dp_s=0.
  - LDI: dp_we=1, dp_s=1, dp_rd=in_imm, dp_aluc=00.
  - CMP: dp_we=0, ALU fields driven.
  - NOP/SKZ: dp_we=0.
- End of ISSUE: ALU/CMP load z_flag←dp_z, v_flag←dp_v, and ovf_sticky |= dp_v. SKZ sets skip_pending if z_flag==1. retire_cnt increments. FSM returns to IDLE. dp_we is cleared at the same edge.
- clr_sticky and a set on the same edge: set wins.
- dp_we is never high outside ISSUE.

## Timing
- Reset (async, immediate): state=IDLE. All dp_* outputs 0. z_flag, v_flag, ovf_sticky, err, skip_pending, retire, retire_cnt all 0. in_ready=1 once in IDLE.
- Reset asserted during ISSUE: dp_we drops asynchronously and no write or flag update occurs.
- Accept at edge k → ISSUE during cycle k..k+1 → register write and flag capture at edge k+1 → in_ready high after edge k+1.
- Throughput: one executed instruction per 2 cycles. Skipped and illegal words consume 1 cycle.
- in_valid held while in_ready=0: word is not consumed. The source must hold in_instr and in_imm stable until the transfer.
- dp_* outputs are registered; they are stable for the whole ISSUE cycle.

## Test plan
- LDI r1←0x5, then LDI r2←0x5, then CMP sub r1,r2 → two 1-cycle dp_we pulses with dp_s=1 and dp_rd=5; CMP drives dp_we=0; z_flag=1, v_flag=0; retire_cnt=3.
- LDI r3←0x7FFFFFFF, LDI r4←1, ALU add r5=r3+r4 → v_flag=1, ovf_sticky=1. Then clr_sticky pulse → ovf_sticky=0 while v_flag stays 1.
- With z_flag=1: SKZ then ALU add r6 → the ALU word is accepted with no ISSUE, no dp_we, no retire; retire_cnt +1 only.
- Opcode 111 → err=1, no dp_we, retire_cnt unchanged. A subsequent NOP executes normally.
- Back-to-back in_valid=1 for 4 words → in_ready toggles 1,0,1,0…; exactly 4 retire pulses over 8 cycles.
- Assert rst_n=0 mid-ISSUE of an ALU op → dp_we=0 immediately, flags 0, and the target register is not written.

Source files
------------

// File: rtl/dp_sequencer.sv
// dp_sequencer: issues one register-file/ALU datapath operation per accepted 32-bit instruction word.
// Latency: accept at edge k, datapath controls are driven during k..k+1, and the write and flag capture happen at edge k+1.
// Backpressure: in_ready is low for the single ISSUE cycle. Skipped and illegal words are consumed in one IDLE cycle.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       instruction handshake; in_instr + in_imm sampled on transfer
//   dp_ra/rb/rw/we/s/aluc/rd registered datapath controls (write only during ISSUE)
//   dp_z, dp_v              datapath zero / signed-overflow, combinational from dp_* drive
//   z_flag, v_flag          flags from the last ALU/CMP
//   ovf_sticky, err         sticky overflow / illegal-opcode; cleared by clr_sticky (set wins)
//   retire, retire_cnt      ISSUE-cycle pulse and wrapping executed-instruction count
module dp_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_imm,
  output logic [4:0]       dp_ra,
  output logic [4:0]       dp_rb,
  output logic [4:0]       dp_rw,
  output logic             dp_we,
  output logic             dp_s,
  output logic [1:0]       dp_aluc,
  output logic [31:0]      dp_rd,
  input  logic             dp_z,
  input  logic             dp_v,
  output logic             z_flag,
  output logic             v_flag,
  output logic             ovf_sticky,
  output logic             err,
  input  logic             clr_sticky,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ALU = 3'b001;
  localparam logic [2:0] OP_LDI = 3'b010;
  localparam logic [2:0] OP_CMP = 3'b011;
  localparam logic [2:0] OP_SKZ = 3'b100;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [4:0]       ra_q, rb_q, rw_q;
  logic             we_q, s_q;
  logic [1:0]       aluc_q;
  logic [31:0]      rd_q;
  logic             z_q, v_q, ovf_q, err_q, skip_q, retire_q;
  logic [CNT_W-1:0] cnt_q;

  // Decode of the word currently on the input bus.
  logic [2:0]  opc;
  logic        illegal;
  logic        accept;
  logic        err_set;
  logic        ovf_set;
  logic        flag_op_q;

  always_comb begin
    opc       = in_instr[31:29];
    illegal   = (opc > OP_SKZ);
    accept    = (state_q == IDLE) && in_valid;
    err_set   = accept && !skip_q && illegal;
    flag_op_q = (op_q == OP_ALU) || (op_q == OP_CMP);
    ovf_set   = (state_q == ISSUE) && flag_op_q && dp_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_NOP;
      ra_q     <= '0;
      rb_q     <= '0;
      rw_q     <= '0;
      we_q     <= 1'b0;
      s_q      <= 1'b0;
      aluc_q   <= '0;
      rd_q     <= '0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      skip_q   <= 1'b0;
      retire_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // Sticky flags: a set on the same edge overrides the clear.
      err_q <= err_set | (err_q & ~clr_sticky);
      ovf_q <= ovf_set | (ovf_q & ~clr_sticky);

      case (state_q)
        IDLE: begin
          if (accept) begin
            if (skip_q) begin
              // Word swallowed by a taken SKZ: no issue, no retire, no count.
              skip_q <= 1'b0;
            end else if (!illegal) begin
              op_q     <= opc;
              ra_q     <= in_instr[21:17];
              rb_q     <= in_instr[16:12];
              rw_q     <= in_instr[26:22];
              we_q     <= (opc == OP_ALU) || (opc == OP_LDI);
              s_q      <= (opc == OP_LDI);
              aluc_q   <= (opc == OP_LDI) ? 2'b00 : in_instr[28:27];
              rd_q     <= (opc == OP_LDI) ? in_imm : 32'd0;
              retire_q <= 1'b1;
              state_q  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (flag_op_q) begin
            z_q <= dp_z;
            v_q <= dp_v;
          end
          // SKZ tests the flag left by the previous ALU/CMP.
          if ((op_q == OP_SKZ) && z_q) begin
            skip_q <= 1'b1;
          end
          cnt_q    <= cnt_q + CNT_W'(1);
          we_q     <= 1'b0;
          retire_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign dp_ra      = ra_q;
  assign dp_rb      = rb_q;
  assign dp_rw      = rw_q;
  assign dp_we      = we_q;
  assign dp_s       = s_q;
  assign dp_aluc    = aluc_q;
  assign dp_rd      = rd_q;
  assign z_flag     = z_q;
  assign v_flag     = v_q;
  assign ovf_sticky = ovf_q;
  assign err        = err_q;
  assign retire     = retire_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed bench for dp_sequencer with a behavioural register-file/ALU datapath attached.
// Latency: follows the DUT (two cycles per executed word, one per skipped or illegal word).
// Backpressure: the source holds each word until in_ready is seen, bounded by a cycle budget.
module tb_dp_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_imm = '0;
  logic [4:0]  dp_ra, dp_rb, dp_rw;
  logic        dp_we, dp_s;
  logic [1:0]  dp_aluc;
  logic [31:0] dp_rd;
  logic        dp_z, dp_v;
  logic        z_flag, v_flag, ovf_sticky, err;
  logic        clr_sticky = 1'b0;
  logic        retire;
  logic [15:0] retire_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  dp_sequencer #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_imm     (in_imm),
    .dp_ra      (dp_ra),
    .dp_rb      (dp_rb),
    .dp_rw      (dp_rw),
    .dp_we      (dp_we),
    .dp_s       (dp_s),
    .dp_aluc    (dp_aluc),
    .dp_rd      (dp_rd),
    .dp_z       (dp_z),
    .dp_v       (dp_v),
    .z_flag     (z_flag),
    .v_flag     (v_flag),
    .ovf_sticky (ovf_sticky),
    .err        (err),
    .clr_sticky (clr_sticky),
    .retire     (retire),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: register file plus combinational ALU.
  logic [31:0] rf [32] = '{default: 32'd0};
  logic [31:0] alu_a, alu_b, alu_r;

  always_comb begin
    alu_a = rf[dp_ra];
    alu_b = rf[dp_rb];
    alu_r = '0;
    dp_v  = 1'b0;
    case (dp_aluc)
      2'b00: begin
        alu_r = alu_a + alu_b;
        dp_v  = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
      end
      2'b01: begin
        alu_r = alu_a - alu_b;
        dp_v  = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
      end
      2'b10: alu_r = alu_a & alu_b;
      default: alu_r = alu_a | alu_b;
    endcase
    dp_z = (alu_r == 32'd0);
  end

  always @(posedge clk) begin
    if (dp_we) rf[dp_rw] <= dp_s ? dp_rd : alu_r;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [1:0] aluc,
                                      input logic [4:0] rw, input logic [4:0] ra,
                                      input logic [4:0] rb);
    return {op, aluc, rw, ra, rb, 12'd0};
  endfunction

  // Presents one word and returns #1 after the edge that transferred it.
  task automatic send(input logic [31:0] ins, input logic [31:0] imm);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = ins;
    in_imm   = imm;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Finish the ISSUE cycle that send() left the DUT in.
  task automatic finish_issue();
    @(posedge clk);
    #1;
  endtask

  int retires;

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",   {31'd0, in_ready},   32'd1);
    check("rst_dp_we",      {31'd0, dp_we},      32'd0);
    check("rst_dp_rd",      dp_rd,               32'd0);
    check("rst_dp_rw",      {27'd0, dp_rw},      32'd0);
    check("rst_flags",      {28'd0, z_flag, v_flag, ovf_sticky, err}, 32'd0);
    check("rst_retire",     {31'd0, retire},     32'd0);
    check("rst_retire_cnt", {16'd0, retire_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // LDI r1<-5, LDI r2<-5, CMP sub r1,r2.
    send(enc(3'b010, 2'b11, 5'd1, 5'd0, 5'd0), 32'd5);
    check("ldi1_we",   {31'd0, dp_we},  32'd1);
    check("ldi1_s",    {31'd0, dp_s},   32'd1);
    check("ldi1_rd",   dp_rd,           32'd5);
    check("ldi1_aluc", {30'd0, dp_aluc}, 32'd0);
    check("ldi1_ret",  {31'd0, retire}, 32'd1);
    check("ldi1_rdy",  {31'd0, in_ready}, 32'd0);
    finish_issue();
    check("ldi1_we_off", {31'd0, dp_we}, 32'd0);
    check("ldi1_r1",     rf[1],          32'd5);
    send(enc(3'b010, 2'b00, 5'd2, 5'd0, 5'd0), 32'd5);
    check("ldi2_we", {31'd0, dp_we}, 32'd1);
    check("ldi2_rd", dp_rd,          32'd5);
    finish_issue();
    check("ldi2_r2", rf[2], 32'd5);
    send(enc(3'b011, 2'b01, 5'd7, 5'd1, 5'd2), 32'd0);
    check("cmp_we",   {31'd0, dp_we},   32'd0);
    check("cmp_aluc", {30'd0, dp_aluc}, 32'd1);
    check("cmp_ret",  {31'd0, retire},  32'd1);
    finish_issue();
    check("cmp_z",   {31'd0, z_flag},     32'd1);
    check("cmp_v",   {31'd0, v_flag},     32'd0);
    check("cmp_r7",  rf[7],               32'd0);
    check("cmp_cnt", {16'd0, retire_cnt}, 32'd3);

    // Signed overflow: 0x7FFFFFFF + 1.
    send(enc(3'b010, 2'b00, 5'd3, 5'd0, 5'd0), 32'h7FFF_FFFF);
    finish_issue();
    send(enc(3'b010, 2'b00, 5'd4, 5'd0, 5'd0), 32'd1);
    finish_issue();
    send(enc(3'b001, 2'b00, 5'd5, 5'd3, 5'd4), 32'd0);
    check("add_we", {31'd0, dp_we}, 32'd1);
    check("add_s",  {31'd0, dp_s},  32'd0);
    finish_issue();
    check("add_r5",  rf[5],               32'h8000_0000);
    check("add_v",   {31'd0, v_flag},     32'd1);
    check("add_z",   {31'd0, z_flag},     32'd0);
    check("add_ovf", {31'd0, ovf_sticky}, 32'd1);
    check("add_cnt", {16'd0, retire_cnt}, 32'd6);
    @(negedge clk);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    check("clr_ovf", {31'd0, ovf_sticky}, 32'd0);
    check("clr_v",   {31'd0, v_flag},     32'd1);

    // Re-establish z=1, then SKZ swallows the following ALU word.
    send(enc(3'b011, 2'b01, 5'd0, 5'd1, 5'd2), 32'd0);
    finish_issue();
    check("cmp2_z", {31'd0, z_flag}, 32'd1);
    send(enc(3'b100, 2'b00, 5'd0, 5'd0, 5'd0), 32'd0);
    finish_issue();
    check("skz_cnt", {16'd0, retire_cnt}, 32'd8);
    send(enc(3'b001, 2'b00, 5'd6, 5'd1, 5'd2), 32'd0);
    check("skip_rdy", {31'd0, in_ready}, 32'd1);
    check("skip_we",  {31'd0, dp_we},    32'd0);
    check("skip_ret", {31'd0, retire},   32'd0);
    finish_issue();
    check("skip_r6",  rf[6],               32'd0);
    check("skip_cnt", {16'd0, retire_cnt}, 32'd8);
    send(enc(3'b000, 2'b00, 5'd0, 5'd0, 5'd0), 32'd0);
    check("nop_after_skip_ret", {31'd0, retire}, 32'd1);
    finish_issue();
    check("nop_after_skip_cnt", {16'd0, retire_cnt}, 32'd9);

    // Illegal opcode.
    send(enc(3'b111, 2'b00, 5'd8, 5'd1, 5'd2), 32'd0);
    check("ill_err", {31'd0, err},        32'd1);
    check("ill_rdy", {31'd0, in_ready},   32'd1);
    check("ill_we",  {31'd0, dp_we},      32'd0);
    check("ill_ret", {31'd0, retire},     32'd0);
    check("ill_cnt", {16'd0, retire_cnt}, 32'd9);
    send(enc(3'b000, 2'b00, 5'd0, 5'd0, 5'd0), 32'd0);
    check("nop_after_ill_ret", {31'd0, retire}, 32'd1);
    finish_issue();
    check("nop_after_ill_cnt", {16'd0, retire_cnt}, 32'd10);
    @(negedge clk);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    check("clr_err", {31'd0, err}, 32'd0);
    // Set and clear on the same edge: set wins.
    clr_sticky = 1'b1;
    send(enc(3'b101, 2'b00, 5'd0, 5'd0, 5'd0), 32'd0);
    clr_sticky = 1'b0;
    check("ill_set_wins", {31'd0, err}, 32'd1);

    // Back-to-back: in_valid held high for 8 cycles.
    retires = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = enc(3'b010, 2'b00, 5'd8, 5'd0, 5'd0);
    in_imm   = 32'h33;
    for (int c = 0; c < 8; c++) begin
      check($sformatf("b2b_rdy%0d", c), {31'd0, in_ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
      if (retire) retires++;
      if (c == 7) in_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b_retires", retires,             32'd4);
    check("b2b_cnt",     {16'd0, retire_cnt}, 32'd14);
    check("b2b_r8",      rf[8],               32'h33);

    // Reset in the middle of an ALU issue: r9 <= r1 + r2 must not happen.
    send(enc(3'b001, 2'b00, 5'd9, 5'd1, 5'd2), 32'd0);
    check("mid_we_pre", {31'd0, dp_we}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_we",    {31'd0, dp_we},      32'd0);
    check("mid_rdy",   {31'd0, in_ready},   32'd1);
    check("mid_flags", {28'd0, z_flag, v_flag, ovf_sticky, err}, 32'd0);
    check("mid_cnt",   {16'd0, retire_cnt}, 32'd0);
    finish_issue();
    check("mid_r9", rf[9], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
